// File: rtl/mont_pkg.sv
// mont_pkg
//   Shared definitions for the Montgomery-domain blocks (mont_reduce,
//   long_div and the planned Montgomery multiplier).
//   Provides the default operand/length widths and the common state
//   encoding used by the bit-serial controllers.
package mont_pkg;

  localparam int W_DEF  = 32;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOP = 2'd1,
    ST_FIX  = 2'd2
  } mont_state_e;

endpackage

// File: rtl/mont_redc_step.sv
// mont_redc_step
//   One combinational iteration of bit-serial Montgomery reduction:
//     t_out = t_in[0] ? (t_in + m_in) >> 1 : t_in >> 1
//   The sum is formed one bit wider than t so a carry out of the top
//   bit survives the shift.
// Ports:
//   t_in  [W:0]   accumulator value before the step
//   m_in  [W-1:0] modulus
//   t_out [W:0]   accumulator value after the step
module mont_redc_step #(
  parameter int W = 32
) (
  input  logic [W:0]   t_in,
  input  logic [W-1:0] m_in,
  output logic [W:0]   t_out
);

  always_comb begin
    if (t_in[0]) begin
      t_out = (W+1)'(({1'b0, t_in} + {2'b00, m_in}) >> 1);
    end else begin
      t_out = t_in >> 1;
    end
  end

endmodule

// File: rtl/mont_reduce.sv
// mont_reduce
//   Bit-serial Montgomery reduction: mr_out = (num_in * 2^-len) mod modulus.
//   Exit path from the Montgomery domain; uses the same start/end pulse
//   handshake as long_div.
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   mr_start        start request, only honoured in IDLE
//   len [LW-1:0]    exponent of R = 2^len
//   num_in [W-1:0]  value to reduce (expected < modulus)
//   modulus [W-1:0] modulus, must be odd
//   mr_busy         high while an operation is in flight
//   mr_end          one-cycle completion pulse
//   mr_err          one-cycle pulse with mr_end when modulus was even
//   mr_out [W-1:0]  result, valid from mr_end until the next result
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for mr_start; also emits the even-modulus error pulse
// LOOP    | one reduction step per cycle, cnt counts down to 1
// FIX     | final conditional subtract, registers result and mr_end
module mont_reduce
  import mont_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          mr_start,
  input  logic [LW-1:0] len,
  input  logic [W-1:0]  num_in,
  input  logic [W-1:0]  modulus,
  output logic          mr_busy,
  output logic          mr_end,
  output logic          mr_err,
  output logic [W-1:0]  mr_out
);

  mont_state_e   state_q, state_d;
  logic [W:0]    t_q, t_d;
  logic [W-1:0]  m_q, m_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d;
  logic          end_q, end_d;
  logic          err_q, err_d;
  // Even modulus is rejected without leaving IDLE; this flag delays the
  // error pulse by one edge so it lands at the same latency as len=0.
  logic          err_pend_q, err_pend_d;

  logic [W:0]    t_step;
  logic          start_acc;

  mont_redc_step #(.W(W)) u_step (
    .t_in  (t_q),
    .m_in  (m_q),
    .t_out (t_step)
  );

  assign start_acc = (state_q == ST_IDLE) && mr_start && !err_pend_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc && modulus[0]) begin
          state_d = (len == '0) ? ST_FIX : ST_LOOP;
        end
      end
      ST_LOOP: begin
        if (cnt_q == LW'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mr_busy = (state_q != ST_IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      t_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      end_q      <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      t_q        <= t_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      end_q      <= end_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  // Datapath next values
  always_comb begin
    t_d        = t_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    end_d      = 1'b0;
    err_d      = 1'b0;
    err_pend_d = 1'b0;

    if (start_acc) begin
      if (modulus[0]) begin
        t_d   = {1'b0, num_in};
        m_d   = modulus;
        cnt_d = len;
      end else begin
        err_pend_d = 1'b1;
      end
    end

    if (err_pend_q) begin
      end_d = 1'b1;
      err_d = 1'b1;
      out_d = '0;
    end

    case (state_q)
      ST_LOOP: begin
        t_d   = t_step;
        cnt_d = cnt_q - LW'(1);
      end
      ST_FIX: begin
        // In contract t < m already; the subtract only matters for
        // out-of-range num_in, where truncation keeps the result stable.
        if (t_q >= {1'b0, m_q}) begin
          out_d = W'(t_q - {1'b0, m_q});
        end else begin
          out_d = t_q[W-1:0];
        end
        end_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign mr_end = end_q;
  assign mr_err = err_q;
  assign mr_out = out_q;

endmodule

// File: doc/mont_reduce.md
# mont_reduce

Bit-serial Montgomery reduction for the modular-arithmetic datapath. Computes mr_out = (num_in · R⁻¹) mod modulus with R = 2^len. It is the exit path from the Montgomery domain, the inverse of the long-division block that maps x to (x · R) mod modulus. It shares that block's start/end pulse handshake so the controller can drive both the same way.

## Interface
Parameters:
- W, default 32: operand width; num_in, modulus and mr_out are W bits.
- LW, default 8: width of len.

Ports:
- clk, input, 1: clock.
- rstn, input, 1: synchronous, active-low reset.
- mr_start, input, 1: start request; sampled only in IDLE.
- len, input, LW: exponent of R; any value 0..2^LW−1 is legal.
- num_in, input, W: value to reduce. Precondition: num_in < modulus.
- modulus, input, W: modulus. Must be odd.
- mr_busy, output, 1: high while not in IDLE.
- mr_end, output, 1: one-cycle completion pulse.
- mr_err, output, 1: one-cycle pulse coincident with mr_end when modulus is even (this includes modulus = 0).
- mr_out, output, W: result; valid from the mr_end cycle, held until the next accepted start.

## Operation
- Registers:
  - t: W+1 bits, the accumulator.
  - m: W bits, the latched modulus.
  - cnt: LW bits, the iteration counter.
  - state.
- States: IDLE, LOOP, FIX.
- IDLE, mr_start=1, modulus[0]=0:
  - Next cycle: mr_end=1, mr_err=1, mr_out=0.
  - Stay in IDLE.
- IDLE, mr_start=1, modulus odd:
  - Load t←num_in, m←modulus, cnt←len.
  - Go to LOOP if len≠0, else go to FIX.
- LOOP, each cycle:
  - If t[0]=1, t←(t+m)>>1; otherwise t←t>>1.
  - The sum t+m is formed at W+1 bits with no truncation before the shift.
  - cnt←cnt−1.
  - When cnt=1 the transition is to FIX.
- FIX:
  - If t≥m, mr_out←t−m; otherwise mr_out←t[W−1:0].
  - mr_end←1, then return to IDLE.
- Invariant: with num_in < m, t < m holds after every LOOP step. FIX subtraction is kept for robustness.
- mr_start while busy: ignored. It is not queued and does not disturb the latched operands.
- mr_start in the same cycle as mr_end is low but state returns to IDLE: it is accepted only once state=IDLE. A start is therefore accepted no earlier than the cycle after mr_end.
- Inputs other than mr_start are sampled only on the accepting edge. They may change freely afterwards.
- Out-of-contract input (num_in ≥ modulus): mr_out is unspecified but deterministic. No error is flagged.

## Timing
- Reset (rstn=0 at an edge):
  - state=IDLE; mr_busy=0, mr_end=0, mr_err=0, mr_out=0.
  - t, m and cnt are cleared.
- Reset mid-operation aborts immediately. mr_end does not pulse and mr_out returns to 0.
- Latency, counting from the edge that accepts mr_start:
  - mr_end rises after len+1 edges.
  - len=0 gives 1 edge.
  - The error path gives 1 edge.
- mr_busy rises the cycle after acceptance and falls in the same cycle that mr_end rises.
- mr_end and mr_err are registered outputs, and each is high for exactly one cycle.
- Throughput: one operation per len+2 cycles at most.

## Structure
- Shared package mont_pkg:
  - W and LW defaults.
  - State enum (IDLE, LOOP, FIX).
  - Reused by long_div and future Montgomery multiplier blocks.
- One natural sub-module: mont_redc_step.
  - Combinational single iteration: (t, m) → t[0] ? (t+m)>>1 : t>>1, at W+1 bits.
  - Instantiated once in the top level, which holds the FSM, counter and output registers.

## Test plan
- Basic reduction:
  - Stimulus: modulus=13, len=4, num_in=5.
  - Required: t sequence 9, 11, 12, 6; mr_out=6, mr_err=0; mr_end exactly 5 edges after the start edge.
- Round trip:
  - Stimulus: long_div(7, len=4, M=13)=8, then mont_reduce(8, 4, 13).
  - Required: mr_out=7.
- Full-width carry:
  - Stimulus: modulus=0xFFFFFFFB, len=32, num_in=1.
  - Required: mr_out=0xCCCCCCC9, latency 33 edges; this path exercises the W+1-bit sum.
- Edge cases:
  - len=0, num_in=9, M=13 → mr_out=9, latency 1.
  - modulus=12 → mr_end and mr_err both pulse one cycle after start, mr_out=0.
- Busy start: mr_start pulsed again while busy with different operands → first result unchanged, no second mr_end.
- Reset mid-operation:
  - Stimulus: rstn=0 at iteration 2 of a len=32 op, then restart.
  - Required: all outputs 0 and no mr_end; the restarted op completes with the correct result.
